// File: rtl/axi_lite_cfg_regs.sv
// AXI4-Lite configuration register bank for the Ethernet example subsystem.
// Holds MAC pattern-generator/checker controls, frame-size limits, an event counter and a sticky error flag.
module axi_lite_cfg_regs #(
    parameter int unsigned ADDR_W    = 18,
    parameter logic [31:0] ID_VALUE  = 32'h4C45_4730,
    parameter logic [31:0] BAD_RDATA = 32'hDEAD_BEEF
) (
    input  logic              axi_lite_clk,
    input  logic              axi_lite_rst,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              soft_rst,
    output logic              pat_gen_enable,
    output logic              pat_chk_enable,
    output logic [1:0]        line_speed,
    output logic [4:0]        pat_gen_en_pkt_types,
    output logic [15:0]       cfg_min_size,
    output logic [15:0]       cfg_max_size,
    input  logic              event_pulse,
    input  logic              err_pulse
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WR_HAVE_AW = 3'd1;
    localparam logic [2:0] S_WR_HAVE_W  = 3'd2;
    localparam logic [2:0] S_WR_RESP    = 3'd3;
    localparam logic [2:0] S_RD_RESP    = 3'd4;

    // Word index of each register; decode is on addr[ADDR_W-1:2] only.
    localparam int IW = ADDR_W - 2;
    localparam logic [IW-1:0] A_ID      = IW'(0);
    localparam logic [IW-1:0] A_CTRL    = IW'(1);
    localparam logic [IW-1:0] A_MIN     = IW'(2);
    localparam logic [IW-1:0] A_MAX     = IW'(3);
    localparam logic [IW-1:0] A_SCRATCH = IW'(4);
    localparam logic [IW-1:0] A_EVT     = IW'(5);
    localparam logic [IW-1:0] A_ERR     = IW'(6);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]    r_state;
    logic [IW-1:0] r_awidx;
    logic [31:0]   r_wdata;
    logic [1:0]    r_bresp;
    logic [31:0]   r_rdata;
    logic [1:0]    r_rresp;
    logic [9:0]    r_ctrl;
    logic [15:0]   r_min;
    logic [15:0]   r_max;
    logic [31:0]   r_scratch;
    logic [31:0]   r_evt;
    logic          r_err;

    logic          w_aw_hs, w_w_hs, w_ar_hs;
    logic          w_wr_commit;
    logic [IW-1:0] w_wr_idx;
    logic [31:0]   w_wr_data;
    logic [IW-1:0] w_rd_idx;
    logic [31:0]   w_rd_data;
    logic [1:0]    w_rd_resp;
    logic          w_unused;

    assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
    assign w_rd_idx = s_axi_araddr[ADDR_W-1:2];

    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_arready = 1'b0;
        case (r_state)
            S_IDLE: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                s_axi_arready = ~s_axi_awvalid & ~s_axi_wvalid;
            end
            S_WR_HAVE_AW: s_axi_wready  = 1'b1;
            S_WR_HAVE_W:  s_axi_awready = 1'b1;
            default: ;
        endcase
    end

    assign w_aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_w_hs  = s_axi_wvalid & s_axi_wready;
    assign w_ar_hs = s_axi_arvalid & s_axi_arready;

    // The half captured first comes from the latch, the other straight from the bus.
    always_comb begin
        w_wr_commit = 1'b0;
        w_wr_idx    = s_axi_awaddr[ADDR_W-1:2];
        w_wr_data   = s_axi_wdata;
        case (r_state)
            S_IDLE:       w_wr_commit = w_aw_hs & w_w_hs;
            S_WR_HAVE_AW: begin
                w_wr_commit = w_w_hs;
                w_wr_idx    = r_awidx;
            end
            S_WR_HAVE_W:  begin
                w_wr_commit = w_aw_hs;
                w_wr_data   = r_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_rd_data = BAD_RDATA;
        w_rd_resp = RESP_OKAY;
        case (w_rd_idx)
            A_ID:      w_rd_data = ID_VALUE;
            A_CTRL:    w_rd_data = {22'd0, r_ctrl};
            A_MIN:     w_rd_data = {16'd0, r_min};
            A_MAX:     w_rd_data = {16'd0, r_max};
            A_SCRATCH: w_rd_data = r_scratch;
            A_EVT:     w_rd_data = r_evt;
            A_ERR:     w_rd_data = {31'd0, r_err};
            default:   w_rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge axi_lite_clk) begin
        if (axi_lite_rst) begin
            r_state   <= S_IDLE;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_bresp   <= RESP_OKAY;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_ctrl    <= 10'h010;
            r_min     <= 16'h0040;
            r_max     <= 16'h0500;
            r_scratch <= '0;
            r_evt     <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs && w_w_hs) begin
                        r_state <= S_WR_RESP;
                    end else if (w_aw_hs) begin
                        r_awidx <= s_axi_awaddr[ADDR_W-1:2];
                        r_state <= S_WR_HAVE_AW;
                    end else if (w_w_hs) begin
                        r_wdata <= s_axi_wdata;
                        r_state <= S_WR_HAVE_W;
                    end else if (w_ar_hs) begin
                        r_rdata <= w_rd_data;
                        r_rresp <= w_rd_resp;
                        r_state <= S_RD_RESP;
                    end
                end
                S_WR_HAVE_AW: if (w_w_hs) r_state <= S_WR_RESP;
                S_WR_HAVE_W:  if (w_aw_hs) r_state <= S_WR_RESP;
                S_WR_RESP:    if (s_axi_bready) r_state <= S_IDLE;
                S_RD_RESP:    if (s_axi_rready) r_state <= S_IDLE;
                default:      r_state <= S_IDLE;
            endcase

            if (w_wr_commit) begin
                r_bresp <= (w_wr_idx <= A_ERR) ? RESP_OKAY : RESP_SLVERR;
                case (w_wr_idx)
                    A_CTRL:    r_ctrl    <= w_wr_data[9:0];
                    A_MIN:     r_min     <= w_wr_data[15:0];
                    A_MAX:     r_max     <= w_wr_data[15:0];
                    A_SCRATCH: r_scratch <= w_wr_data;
                    default: ;
                endcase
            end

            if (w_ar_hs && (w_rd_idx == A_EVT))
                r_evt <= {31'd0, event_pulse};
            else if (event_pulse && (r_evt != 32'hFFFF_FFFF))
                r_evt <= r_evt + 32'd1;

            if (err_pulse)
                r_err <= 1'b1;
            else if (w_wr_commit && (w_wr_idx == A_ERR) && w_wr_data[0])
                r_err <= 1'b0;
        end
    end

    assign s_axi_bvalid = (r_state == S_WR_RESP);
    assign s_axi_bresp  = r_bresp;
    assign s_axi_rvalid = (r_state == S_RD_RESP);
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rresp  = r_rresp;

    assign soft_rst             = r_ctrl[0];
    assign pat_gen_enable       = r_ctrl[1];
    assign pat_chk_enable       = r_ctrl[2];
    assign line_speed           = r_ctrl[4:3];
    assign pat_gen_en_pkt_types = r_ctrl[9:5];
    assign cfg_min_size         = r_min;
    assign cfg_max_size         = r_max;
endmodule

// File: tb/tb_axi_lite_cfg_regs.sv
// Directed bench for axi_lite_cfg_regs: register map, write ordering, event counter, sticky flag, errors and reset.
module tb_axi_lite_cfg_regs;
    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [1:0]  bresp, rresp, line_speed;
    logic        arvalid, arready, rvalid, rready;
    logic        soft_rst, pat_gen_enable, pat_chk_enable;
    logic [4:0]  pkt_types;
    logic [15:0] min_size, max_size;
    logic        event_pulse, err_pulse;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_lite_cfg_regs dut (
        .axi_lite_clk(clk), .axi_lite_rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .soft_rst(soft_rst), .pat_gen_enable(pat_gen_enable), .pat_chk_enable(pat_chk_enable),
        .line_speed(line_speed), .pat_gen_en_pkt_types(pkt_types),
        .cfg_min_size(min_size), .cfg_max_size(max_size),
        .event_pulse(event_pulse), .err_pulse(err_pulse)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // aw_at / w_at: cycle at which each channel is first presented; ep drives err_pulse in cycle 0.
    task automatic axi_wr(input string tag, input logic [17:0] a, input logic [31:0] d,
                          input int aw_at, input int w_at, input logic ep, input int bhold,
                          input logic [1:0] exp_resp);
        logic aw_d, w_d, aw_h, w_h;
        aw_d = 1'b0;
        w_d  = 1'b0;
        for (int t = 0; t < 20 && !(aw_d && w_d); t++) begin
            @(negedge clk);
            if (!aw_d && t >= aw_at) begin awvalid = 1'b1; awaddr = a; end
            if (!w_d && t >= w_at) begin wvalid = 1'b1; wdata = d; end
            if (t == 0) err_pulse = ep;
            #1;
            aw_h = awvalid && awready;
            w_h  = wvalid && wready;
            @(posedge clk);
            #1;
            err_pulse = 1'b0;
            if (aw_h) begin aw_d = 1'b1; awvalid = 1'b0; end
            if (w_h) begin w_d = 1'b1; wvalid = 1'b0; end
            if (!(aw_d && w_d)) check_vec({tag, "/early_bvalid"}, bvalid, 1'b0);
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check_vec({tag, "/wr_handshake"}, aw_d && w_d, 1'b1);
        check_vec({tag, "/bvalid"}, bvalid, 1'b1);
        check_vec({tag, "/bresp"}, bresp, exp_resp);
        for (int i = 0; i < bhold; i++) begin
            @(negedge clk);
            check_vec({tag, "/bvalid_hold"}, bvalid, 1'b1);
            check_vec({tag, "/bresp_hold"}, bresp, exp_resp);
        end
        @(negedge clk);
        bready = 1'b1;
        @(posedge clk);
        #1;
        bready = 1'b0;
        check_vec({tag, "/bvalid_drop"}, bvalid, 1'b0);
    endtask

    task automatic axi_rd(input string tag, input logic [17:0] a, input logic evp, input int rhold,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic hs;
        hs = 1'b0;
        @(negedge clk);
        arvalid = 1'b1;
        araddr = a;
        event_pulse = evp;
        for (int t = 0; t < 20 && !hs; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            hs = arready;
            @(posedge clk);
            #1;
            event_pulse = 1'b0;
        end
        arvalid = 1'b0;
        check_vec({tag, "/ar_handshake"}, hs, 1'b1);
        check_vec({tag, "/rvalid"}, rvalid, 1'b1);
        check_vec({tag, "/rdata"}, rdata, exp_data);
        check_vec({tag, "/rresp"}, rresp, exp_resp);
        for (int i = 0; i < rhold; i++) begin
            @(negedge clk);
            check_vec({tag, "/rvalid_hold"}, rvalid, 1'b1);
            check_vec({tag, "/rdata_hold"}, rdata, exp_data);
            check_vec({tag, "/rresp_hold"}, rresp, exp_resp);
        end
        @(negedge clk);
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
        check_vec({tag, "/rvalid_drop"}, rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        awaddr = '0; araddr = '0; wdata = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0;
        event_pulse = 1'b0; err_pulse = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset values and outputs
        check_vec("rst/line_speed", line_speed, 2'b10);
        check_vec("rst/soft_rst", soft_rst, 1'b0);
        check_vec("rst/min_size", min_size, 16'h0040);
        check_vec("rst/max_size", max_size, 16'h0500);
        check_vec("rst/bvalid", bvalid, 1'b0);
        check_vec("rst/rvalid", rvalid, 1'b0);
        axi_rd("rd_id", 18'h00, 1'b0, 0, 32'h4C45_4730, 2'b00);
        axi_rd("rd_ctrl", 18'h04, 1'b0, 0, 32'h0000_0010, 2'b00);
        axi_rd("rd_min", 18'h08, 1'b0, 0, 32'h0000_0040, 2'b00);
        axi_rd("rd_max", 18'h0C, 1'b0, 0, 32'h0000_0500, 2'b00);

        // CTRL writes with the three channel orderings
        axi_wr("ctrl_same", 18'h04, 32'h0000_03FF, 0, 0, 1'b0, 0, 2'b00);
        check_vec("ctrl_same/soft_rst", soft_rst, 1'b1);
        check_vec("ctrl_same/pkt_types", pkt_types, 5'h1F);
        check_vec("ctrl_same/line_speed", line_speed, 2'b11);
        axi_rd("rd_ctrl_3ff", 18'h04, 1'b0, 0, 32'h0000_03FF, 2'b00);
        axi_wr("ctrl_zero1", 18'h04, 32'hFFFF_FC00, 0, 0, 1'b0, 0, 2'b00);
        check_vec("ctrl_zero1/soft_rst", soft_rst, 1'b0);
        axi_wr("ctrl_w_first", 18'h04, 32'h0000_03FF, 3, 0, 1'b0, 0, 2'b00);
        check_vec("ctrl_w_first/soft_rst", soft_rst, 1'b1);
        check_vec("ctrl_w_first/pkt_types", pkt_types, 5'h1F);
        axi_wr("ctrl_zero2", 18'h04, 32'h0000_0000, 0, 0, 1'b0, 0, 2'b00);
        check_vec("ctrl_zero2/pkt_types", pkt_types, 5'h00);
        axi_wr("ctrl_aw_first", 18'h04, 32'h0000_03FF, 0, 2, 1'b0, 0, 2'b00);
        check_vec("ctrl_aw_first/soft_rst", soft_rst, 1'b1);
        check_vec("ctrl_aw_first/pkt_types", pkt_types, 5'h1F);
        check_vec("ctrl_aw_first/gen_en", pat_gen_enable, 1'b1);
        check_vec("ctrl_aw_first/chk_en", pat_chk_enable, 1'b1);

        // frame sizes, upper bits dropped, addr[1:0] ignored
        axi_wr("min_wr", 18'h08, 32'hFFFF_1234, 0, 0, 1'b0, 0, 2'b00);
        check_vec("min_wr/out", min_size, 16'h1234);
        axi_rd("rd_min_off3", 18'h0B, 1'b0, 0, 32'h0000_1234, 2'b00);
        axi_wr("max_wr", 18'h0E, 32'h0000_05EE, 0, 0, 1'b0, 0, 2'b00);
        check_vec("max_wr/out", max_size, 16'h05EE);

        // read-only registers ignore writes with OKAY
        axi_wr("id_wr", 18'h00, 32'h1234_5678, 0, 0, 1'b0, 0, 2'b00);
        axi_rd("rd_id_after", 18'h00, 1'b0, 0, 32'h4C45_4730, 2'b00);

        // event counter
        @(negedge clk);
        event_pulse = 1'b1;
        repeat (5) @(negedge clk);
        event_pulse = 1'b0;
        axi_wr("evt_wr", 18'h14, 32'h0000_00AA, 0, 0, 1'b0, 0, 2'b00);
        axi_rd("evt_rd5", 18'h14, 1'b0, 0, 32'd5, 2'b00);
        axi_rd("evt_rd0", 18'h14, 1'b1, 0, 32'd0, 2'b00);
        axi_rd("evt_rd1", 18'h14, 1'b0, 0, 32'd1, 2'b00);

        // sticky error flag
        @(negedge clk);
        err_pulse = 1'b1;
        @(negedge clk);
        err_pulse = 1'b0;
        axi_rd("err_set", 18'h18, 1'b0, 0, 32'd1, 2'b00);
        axi_wr("err_w0", 18'h18, 32'd0, 0, 0, 1'b0, 0, 2'b00);
        axi_rd("err_w0_rd", 18'h18, 1'b0, 0, 32'd1, 2'b00);
        axi_wr("err_w1c_pulse", 18'h18, 32'd1, 0, 0, 1'b1, 0, 2'b00);
        axi_rd("err_setwins", 18'h18, 1'b0, 0, 32'd1, 2'b00);
        axi_wr("err_w1c", 18'h18, 32'd1, 0, 0, 1'b0, 0, 2'b00);
        axi_rd("err_cleared", 18'h18, 1'b0, 0, 32'd0, 2'b00);

        // unmapped accesses with back-pressure
        axi_wr("scr_wr", 18'h10, 32'hA5A5_1234, 0, 0, 1'b0, 0, 2'b00);
        axi_wr("bad_wr", 18'h1FC, 32'h0BAD_0BAD, 0, 0, 1'b0, 4, 2'b10);
        axi_wr("bad_wr_1c", 18'h1C, 32'h0BAD_0BAD, 1, 0, 1'b0, 0, 2'b10);
        axi_wr("bad_wr_alias", 18'h10010, 32'h0BAD_0BAD, 0, 1, 1'b0, 0, 2'b10);
        axi_rd("bad_rd", 18'h1FC, 1'b0, 4, 32'hDEAD_BEEF, 2'b10);
        axi_rd("bad_rd_alias", 18'h10004, 1'b0, 0, 32'hDEAD_BEEF, 2'b10);
        axi_rd("scr_kept", 18'h10, 1'b0, 0, 32'hA5A5_1234, 2'b00);

        // simultaneous write and read: write first, read waits
        @(negedge clk);
        awvalid = 1'b1; awaddr = 18'h10;
        wvalid = 1'b1; wdata = 32'h5A5A_0001;
        arvalid = 1'b1; araddr = 18'h10;
        #1;
        check_vec("arb/arready_idle", arready, 1'b0);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid = 1'b0;
        check_vec("arb/bvalid", bvalid, 1'b1);
        check_vec("arb/arready_wresp", arready, 1'b0);
        check_vec("arb/rvalid", rvalid, 1'b0);
        @(negedge clk);
        bready = 1'b1;
        @(posedge clk);
        #1;
        bready = 1'b0;
        check_vec("arb/arready_back", arready, 1'b1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        check_vec("arb/rvalid_late", rvalid, 1'b1);
        check_vec("arb/rdata_new", rdata, 32'h5A5A_0001);
        @(negedge clk);
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;

        // reset with a half-write pending
        @(negedge clk);
        awvalid = 1'b1; awaddr = 18'h10;
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        check_vec("halfwr/awready", awready, 1'b0);
        check_vec("halfwr/wready", wready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_vec("halfwr_rst/bvalid", bvalid, 1'b0);
        check_vec("halfwr_rst/awready", awready, 1'b1);
        check_vec("halfwr_rst/arready", arready, 1'b1);
        check_vec("halfwr_rst/line_speed", line_speed, 2'b10);
        check_vec("halfwr_rst/soft_rst", soft_rst, 1'b0);
        axi_rd("halfwr_rst/scratch", 18'h10, 1'b0, 0, 32'd0, 2'b00);
        axi_rd("halfwr_rst/min", 18'h08, 1'b0, 0, 32'h0000_0040, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
